// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator front end.
//   KEY_W       : width of a key code on the keypad interface
//   KEY_NONE    : key code reported while no key is accepted
//   kp_state_t  : keypad debounce FSM states
//   kp_result_t : classification of one full matrix scan
// Helper functions summarise one column's 4 bit-line sample.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int KEY_W = 5;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } kp_result_t;

    // Number of asserted bits, saturating at 2 (we only care about 0/1/many).
    function automatic logic [1:0] count_sat2(input logic [3:0] bits);
        logic [2:0] total;
        total = 3'(bits[0]) + 3'(bits[1]) + 3'(bits[2]) + 3'(bits[3]);
        return (total >= 3'd2) ? 2'd2 : total[1:0];
    endfunction

    // Index of the lowest asserted bit; 0 when none is set.
    function automatic logic [1:0] first_bit(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bits[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// ---------------------------------------------------------------------------
// keypad_col_driver
// Walks the keypad word lines: each of the 4 columns is driven for SCAN_DIV
// clocks, and the bit lines are sampled on the last clock of each dwell so
// the matrix has settled.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : low parks the driver (no drive, column/dwell cleared)
//   word_lines[4] : one-hot active-high word-line drive
//   col[2]        : column currently driven
//   sample        : bit lines are valid to sample this cycle
//   scan_end      : sample cycle of column 3 (a full scan completes)
// ---------------------------------------------------------------------------
module keypad_col_driver #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [3:0] word_lines,
    output logic [1:0] col,
    output logic       sample,
    output logic       scan_end
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic             drive_en_q;

    // drive_en_q resets high so the word lines come out of reset at 0001,
    // and drops for a disabled period. On re-enable it is raised first
    // with the counters still at zero, so the restart gets a full dwell.
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q    <= '0;
            col_q      <= 2'd0;
            drive_en_q <= 1'b1;
        end else if (!enable) begin
            dwell_q    <= '0;
            col_q      <= 2'd0;
            drive_en_q <= 1'b0;
        end else if (!drive_en_q) begin
            drive_en_q <= 1'b1;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;   // 3 -> 0 wraps naturally
        end else begin
            dwell_q <= dwell_q + DIV_W'(1);
        end
    end

    assign col        = col_q;
    assign word_lines = drive_en_q ? (4'b0001 << col_q) : 4'b0000;
    assign sample     = enable && drive_en_q && (dwell_q == DWELL_LAST);
    assign scan_end   = sample && (col_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Owns the 4x4 calculator keypad: scans the matrix, debounces press and
// release over whole scans, and reports one key event per press.
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key stays held, a new
// o_key_valid pulse is issued every REPEAT_SCANS scans.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_enable        : low forces idle (no drive, outputs cleared)
//   i_bit_lines[4]  : synchronised matrix bit lines, active high
//   o_word_lines[4] : one-hot active-high word-line drive
//   o_key_value[5]  : accepted key code (word*4 + bit), 5'h1F when none
//   o_key_valid     : one-cycle pulse per key event
//   o_key_held      : high while the accepted key remains held
// ---------------------------------------------------------------------------
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [3:0]       i_bit_lines,
    output logic [3:0]       o_word_lines,
    output logic [KEY_W-1:0] o_key_value,
    output logic             o_key_valid,
    output logic             o_key_held
);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV>=2, DEBOUNCE_SCANS>=1, REPEAT_SCANS>=1 required");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    // ---------------------------------------------------------------
    // Column sequencing
    // ---------------------------------------------------------------
    logic [1:0] col;
    logic       sample;
    logic       scan_end;

    keypad_col_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_driver (
        .clk        (clk),
        .rst        (rst),
        .enable     (i_enable),
        .word_lines (o_word_lines),
        .col        (col),
        .sample     (sample),
        .scan_end   (scan_end)
    );

    // ---------------------------------------------------------------
    // Per-scan accumulator: key count (0/1/many) and first code seen.
    // The column-3 sample is folded in combinationally so the scan
    // result is complete on the scan_end cycle itself.
    // ---------------------------------------------------------------
    logic [1:0] acc_cnt_q;
    logic [3:0] acc_code_q;
    logic [2:0] cnt_sum;
    logic [1:0] scan_cnt;
    logic [3:0] scan_code;
    kp_result_t scan_result;

    assign cnt_sum   = {1'b0, acc_cnt_q} + {1'b0, count_sat2(i_bit_lines)};
    assign scan_cnt  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
    // Scan order is column 0..3, bit 0..3: an earlier hit keeps priority.
    assign scan_code = (acc_cnt_q != 2'd0) ? acc_code_q : {col, first_bit(i_bit_lines)};

    // NOTE: every signal written in an always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        scan_result = NONE;
        case (scan_cnt)
            2'd1:    scan_result = ONE;
            2'd2:    scan_result = MULTI;
            default: scan_result = NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (!i_enable || scan_end) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (sample) begin
            acc_cnt_q  <= scan_cnt;
            acc_code_q <= scan_code;
        end
    end

    // ---------------------------------------------------------------
    // Debounce FSM, advanced only at scan end
    // ---------------------------------------------------------------
    kp_state_t        state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] value_d;
    logic             valid_d;
    logic             held_d;
    logic             same_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);
    logic [REP_W-1:0] rep_q, rep_d, rep_inc;
    assign rep_inc = rep_q + REP_W'(1);
`endif

    assign cnt_inc  = cnt_q + CNT_W'(1);
    // MULTI never matches, so it behaves as NONE for release purposes.
    assign same_key = (scan_result == ONE) && (scan_code == cand_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = o_key_value;
        held_d  = o_key_held;
        valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (!i_enable) begin
            state_d = IDLE;
            cand_d  = 4'd0;
            cnt_d   = '0;
            value_d = KEY_NONE;
            held_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
        end else if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (scan_result == ONE) begin
                        cand_d = scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            value_d = {1'b0, scan_code};
                            held_d  = 1'b1;
                            valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = PRESS;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS: begin
                    if (same_key) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            value_d = {1'b0, cand_q};
                            held_d  = 1'b1;
                            valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (scan_result == ONE) begin
                        // A different single key restarts debouncing on it.
                        cand_d = scan_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (same_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_inc == REP_MAX) begin
                            rep_d   = '0;
                            valid_d = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        value_d = KEY_NONE;
                        held_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (same_key) begin
                        // Bounce back onto the held key: no new event.
                        state_d = HELD;
                        cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (cnt_inc == CNT_MAX) begin
                        // A different key is ignored until IDLE is reached.
                        state_d = IDLE;
                        cnt_d   = '0;
                        value_d = KEY_NONE;
                        held_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            o_key_value <= KEY_NONE;
            o_key_valid <= 1'b0;
            o_key_held  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            o_key_value <= value_d;
            o_key_valid <= valid_d;
            o_key_held  <= held_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2,
// REPEAT_SCANS=3 (one full scan = 16 clocks). A physical 4x4 matrix model
// turns the set of pressed keys plus the driven word line into bit lines.
// Inputs change half a cycle away from the active edge, on scan boundaries.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [3:0]  i_bit_lines;
    logic [3:0]  o_word_lines;
    logic [4:0]  o_key_value;
    logic        o_key_valid;
    logic        o_key_held;

    logic [15:0] keys;         // bit k set = key code k is physically pressed
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [4:0]  last_value = 5'h00;

    localparam int SCAN = 16;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_bit_lines  (i_bit_lines),
        .o_word_lines (o_word_lines),
        .o_key_value  (o_key_value),
        .o_key_valid  (o_key_valid),
        .o_key_held   (o_key_held)
    );

    // Matrix: a pressed key at (word w, bit b) shorts word line w onto bit b.
    always_comb begin
        i_bit_lines = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (keys[w*4 + b] && o_word_lines[w]) i_bit_lines[b] = 1'b1;
            end
        end
    end

    // Count every cycle in which o_key_valid is high (one count per pulse cycle).
    always @(negedge clk) begin
        if (o_key_valid === 1'b1) begin
            pulses     <= pulses + 1;
            last_value <= o_key_value;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance n falling edges, then 1 time unit so the pulse counter settles.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        i_enable = 1'b1;
        keys     = 16'h0000;
        repeat (2) @(negedge clk);

        // ---- reset values ----
        check("rst_word", 32'(o_word_lines), 32'h1);
        check("rst_value", 32'(o_key_value), 32'h1F);
        check("rst_valid", 32'(o_key_valid), 32'h0);
        check("rst_held", 32'(o_key_held), 32'h0);

        // ---- idle scanning: word lines walk every 4 clocks ----
        rst = 1'b0;
        #1;
        check("scan_col0", 32'(o_word_lines), 32'h1);
        step(4);  check("scan_col1", 32'(o_word_lines), 32'h2);
        step(4);  check("scan_col2", 32'(o_word_lines), 32'h4);
        step(4);  check("scan_col3", 32'(o_word_lines), 32'h8);
        step(4);  check("scan_wrap", 32'(o_word_lines), 32'h1);
        check("idle_value", 32'(o_key_value), 32'h1F);
        check("idle_pulses", 32'(pulses), 32'd0);

        // ---- press code 6 (word1/bit2) for 3 scans ----
        keys = 16'h0040;
        step(SCAN);
        check("p6_scan1_held", 32'(o_key_held), 32'h0);
        check("p6_scan1_pulses", 32'(pulses), 32'd0);
        step(SCAN);
        check("p6_accept_valid", 32'(o_key_valid), 32'h1);
        check("p6_accept_value", 32'(o_key_value), 32'h6);
        check("p6_accept_held", 32'(o_key_held), 32'h1);
        step(SCAN);
        check("p6_one_pulse", 32'(pulses), 32'd1);
        check("p6_still_held", 32'(o_key_held), 32'h1);

        // ---- 1-scan bounce then clean release ----
        keys = 16'h0000;
        step(SCAN);
        check("bounce_rel_held", 32'(o_key_held), 32'h1);
        keys = 16'h0040;
        step(SCAN);
        check("bounce_value", 32'(o_key_value), 32'h6);
        check("bounce_pulses", 32'(pulses), 32'd1);
        keys = 16'h0000;
        step(SCAN);
        check("rel_scan1_held", 32'(o_key_held), 32'h1);
        step(SCAN);
        check("rel_scan2_held", 32'(o_key_held), 32'h0);
        check("rel_scan2_value", 32'(o_key_value), 32'h1F);

        // ---- codes 3 and 12 together: no event; then 12 released ----
        keys = 16'h1008;
        step(5 * SCAN);
        check("multi_pulses", 32'(pulses), 32'd1);
        check("multi_held", 32'(o_key_held), 32'h0);
        check("multi_value", 32'(o_key_value), 32'h1F);
        keys = 16'h0008;
        step(SCAN);
        check("k3_scan1_pulses", 32'(pulses), 32'd1);
        step(SCAN);
        check("k3_accept_valid", 32'(o_key_valid), 32'h1);
        check("k3_accept_value", 32'(o_key_value), 32'h3);
        check("k3_pulses", 32'(pulses), 32'd2);

        // ---- drop enable while HELD ----
        i_enable = 1'b0;
        step(1);
        check("dis_word", 32'(o_word_lines), 32'h0);
        check("dis_value", 32'(o_key_value), 32'h1F);
        check("dis_held", 32'(o_key_held), 32'h0);
        check("dis_valid", 32'(o_key_valid), 32'h0);
        keys = 16'h0000;
        step(20);
        check("dis_word_stays", 32'(o_word_lines), 32'h0);
        check("dis_pulses", 32'(pulses), 32'd2);
        i_enable = 1'b1;
        step(1);
        check("reen_col0", 32'(o_word_lines), 32'h1);
        step(4);
        check("reen_col1", 32'(o_word_lines), 32'h2);
        step(12);

        // ---- reset in the middle of PRESS ----
        keys = 16'h0040;
        step(SCAN);
        check("pre_rst_pulses", 32'(pulses), 32'd2);
        step(5);
        rst = 1'b1;
        #1;
        check("mid_rst_word", 32'(o_word_lines), 32'h1);
        check("mid_rst_value", 32'(o_key_value), 32'h1F);
        check("mid_rst_held", 32'(o_key_held), 32'h0);
        check("mid_rst_valid", 32'(o_key_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(SCAN);
        check("post_rst_no_early", 32'(pulses), 32'd2);
        step(SCAN);
        check("post_rst_value", 32'(o_key_value), 32'h6);
        check("post_rst_pulses", 32'(pulses), 32'd3);

        // ---- different key while held: ignored until IDLE ----
        keys = 16'h0200;
        step(SCAN);
        check("swap_rel_value", 32'(o_key_value), 32'h6);
        step(SCAN);
        check("swap_idle_value", 32'(o_key_value), 32'h1F);
        check("swap_idle_held", 32'(o_key_held), 32'h0);
        step(SCAN);
        check("swap_press_pulses", 32'(pulses), 32'd3);
        step(SCAN);
        check("swap_accept_value", 32'(o_key_value), 32'h9);
        check("swap_pulses", 32'(pulses), 32'd4);

`ifdef KEYPAD_AUTOREPEAT_EN
        // ---- auto-repeat: hold code 9 for 10 scans ----
        keys = 16'h0000;
        step(2 * SCAN);
        keys = 16'h0200;
        step(2 * SCAN);
        check("rep_accept_valid", 32'(o_key_valid), 32'h1);
        check("rep_accept_pulses", 32'(pulses), 32'd5);
        step(8 * SCAN);
        check("rep_pulses", 32'(pulses), 32'd7);
        check("rep_last_value", 32'(last_value), 32'h9);
        keys = 16'h0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
